prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side checker for the 9-bit XNOR LFSR pattern generator (taps 9,5; one shift per enabled cycle).
//  Takes one received LFSR state word per i_valid, self-synchronises by seeding from the stream,
//  then compares each word against the locally predicted next state. Reports lock status and counts errors.
//  Sits after the UART receive path to qualify the link with test-pattern traffic.
// PARAMETERS
//  NUM_BITS    9   LFSR width; feedback is XNOR of state bits TAP_A and TAP_B (1-based numbering)
//  TAP_A       9   first feedback tap, 1-based
//  TAP_B       5   second feedback tap, 1-based
//  LOCK_COUNT  8   consecutive matches in VERIFY required to enter LOCKED (1..255)
//  LOSS_COUNT  4   consecutive mismatches in LOCKED that drop lock (1..255)
//  CNT_W       16  width of the error and word counters
// PORTS
//  clk           in   1         clock, rising edge
//  reset         in   1         synchronous, active-high
//  i_clear       in   1         zero both counters and o_lock_lost; lock state is unaffected
//  i_valid       in   1         i_data holds a received word this cycle
//  i_data        in   NUM_BITS  received LFSR state word
//  o_state       out  2         0=HUNT 1=VERIFY 2=LOCKED (3 unused)
//  o_locked      out  1         state==LOCKED
//  o_err_pulse   out  1         one-cycle pulse: mismatch while LOCKED
//  o_err_count   out  CNT_W     mismatches counted while LOCKED, saturating
//  o_word_count  out  CNT_W     valid words received while LOCKED, saturating
//  o_lock_lost   out  1         sticky: set on a LOCKED->HUNT transition
// BEHAVIOUR
//  - Reset: state HUNT; ref, match_cnt, miss_cnt cleared; every output 0.
//  - Next-state function: nxt(s) = {s[NUM_BITS-1:1], ~(s[TAP_A]^s[TAP_B])}, 1-based indexing.
//    Shift toward the MSB; the new bit enters at the LSB. It must match the generator exactly.
//  - No state or counter changes on any cycle where i_valid=0. Gaps of any length are allowed.
//  - HUNT: on valid, ref<=i_data and go to VERIFY with match_cnt=0.
//    Exception: i_data all-ones (XNOR lock-up state) is ignored and the block stays in HUNT.
//  - VERIFY: on valid, compare i_data with nxt(ref).
//    match: ref<=i_data, match_cnt++; when match_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
//    mismatch: ref<=i_data (reseed), match_cnt<=0, stay in VERIFY. Not counted as an error.
//  - LOCKED: on valid, ref<=nxt(ref) (flywheel: never reseed from corrupt data); o_word_count++.
//    match: miss_cnt<=0.
//    mismatch: o_err_pulse=1, o_err_count++, miss_cnt++.
//      When miss_cnt reaches LOSS_COUNT: go to HUNT, o_lock_lost<=1, match_cnt<=0.
//  - Latency: all outputs are registered and reflect the i_valid word on the next clock edge.
//    o_err_pulse lasts exactly one cycle per bad word.
//  - Counters saturate at all-ones and do not wrap.
//  - i_clear together with an increment: the counters end at 0 (clear wins).
//    i_clear together with lock loss: o_lock_lost ends at 1 (set wins).
//  - reset in any state, including mid-VERIFY or LOCKED: full return to the reset values on the next edge.
// STRUCTURE
//  - Package prbs_pkg: state encoding constants (ST_HUNT/ST_VERIFY/ST_LOCKED), default tap constants.
//  - Sub-module lfsr_step (combinational): NUM_BITS/TAP_A/TAP_B params, s in, nxt(s) out.
//    It is shared with the generator-side model in the bench.
//  - Top: 2-bit state register, ref register, match_cnt/miss_cnt (8 bit), two saturating counters.
// TESTING
//  T1 lock: feed 000,001,003,007,00F,01F,03E,07C,0F8 (hex) from reset.
//     -> o_state goes HUNT->VERIFY->LOCKED after the 9th word; o_err_count=0.
//  T2 single error: locked, flip bit 0 of one word -> o_err_pulse for 1 cycle, o_err_count=1, still locked.
//     The next correct word matches; o_word_count keeps incrementing.
//  T3 loss: locked, 4 consecutive corrupted words -> lock drops on the 4th.
//     o_lock_lost=1, o_err_count=4, o_state=HUNT.
//  T4 lock-up: in HUNT, drive 1FF for 20 valid cycles -> stays HUNT; no pulses; counters 0.
//  T5 valid gaps: lock with random i_valid=0 gaps of 0-7 cycles -> identical result to T1.
//  T6 clear/reset: i_clear on the same cycle as a mismatch -> o_err_count=0.
//     reset asserted mid-VERIFY -> all outputs 0, state HUNT next cycle.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared encodings and default geometry for the PRBS-9 receive checker.
// Imported by the interface, the LFSR step function and the checker top.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int DEF_NUM_BITS   = 9;
  localparam int DEF_TAP_A      = 9;
  localparam int DEF_TAP_B      = 5;
  localparam int DEF_LOCK_COUNT = 8;
  localparam int DEF_LOSS_COUNT = 4;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/prbs_checker_if.sv
// Received-word input and status/counter outputs of the PRBS checker.
// The master drives received words; the slave (checker) reports lock and error status.
interface prbs_checker_if
  import prbs_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int CNT_W    = DEF_CNT_W
);

  logic                i_clear;
  logic                i_valid;
  logic [NUM_BITS-1:0] i_data;

  logic [1:0]          o_state;
  logic                o_locked;
  logic                o_err_pulse;
  logic [CNT_W-1:0]    o_err_count;
  logic [CNT_W-1:0]    o_word_count;
  logic                o_lock_lost;

  modport master (
    output i_clear, i_valid, i_data,
    input  o_state, o_locked, o_err_pulse, o_err_count, o_word_count, o_lock_lost
  );

  modport slave (
    input  i_clear, i_valid, i_data,
    output o_state, o_locked, o_err_pulse, o_err_count, o_word_count, o_lock_lost
  );

endinterface

// File: rtl/lfsr_step.sv
// One step of the XNOR Fibonacci LFSR used by the pattern generator.
// Taps are 1-based; the state shifts toward the MSB and the feedback bit enters at the LSB.
module lfsr_step
  import prbs_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int TAP_A    = DEF_TAP_A,
  parameter int TAP_B    = DEF_TAP_B
) (
  input  logic [NUM_BITS-1:0] s,
  output logic [NUM_BITS-1:0] nxt
);

  // The old MSB falls off the top; XNOR feedback makes all-ones the lock-up state.
  assign nxt = {s[NUM_BITS-2:0], ~(s[TAP_A-1] ^ s[TAP_B-1])};

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds from the stream, verifies a run of matches,
// then flywheels a local prediction while counting words and bit-pattern errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int NUM_BITS   = DEF_NUM_BITS,
  parameter int TAP_A      = DEF_TAP_A,
  parameter int TAP_B      = DEF_TAP_B,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  prbs_checker_if.slave  bus
);

  localparam logic [7:0]          LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0]          LOSS_C = 8'(LOSS_COUNT);
  localparam logic [NUM_BITS-1:0] LOCKUP = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] ref_q, ref_d, ref_pred;
  logic [7:0]          match_q, match_d;
  logic [7:0]          miss_q, miss_d;
  logic                is_match;
  logic                err_evt, word_evt, loss_evt;

  logic                err_pulse_q;
  logic                lock_lost_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [CNT_W-1:0]    word_cnt_q;

  lfsr_step #(
    .NUM_BITS (NUM_BITS),
    .TAP_A    (TAP_A),
    .TAP_B    (TAP_B)
  ) u_step (
    .s   (ref_q),
    .nxt (ref_pred)
  );

  assign is_match = (bus.i_data == ref_pred);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_evt  = 1'b0;
    word_evt = 1'b0;
    loss_evt = 1'b0;

    if (bus.i_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.i_data != LOCKUP) begin
            ref_d   = bus.i_data;
            match_d = '0;
            state_d = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          // Always reseed from the stream while verifying; a miss just restarts the run.
          ref_d = bus.i_data;
          if (is_match) begin
            match_d = match_q + 8'd1;
            if (match_q + 8'd1 == LOCK_C) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel on the local prediction so corrupt words never poison the reference.
          ref_d    = ref_pred;
          word_evt = 1'b1;
          if (is_match) begin
            miss_d = '0;
          end else begin
            err_evt = 1'b1;
            miss_d  = miss_q + 8'd1;
            if (miss_q + 8'd1 == LOSS_C) begin
              state_d  = ST_HUNT;
              loss_evt = 1'b1;
              match_d  = '0;
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      ref_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_evt;

      // Clear beats a same-cycle increment.
      if (bus.i_clear) begin
        err_cnt_q  <= '0;
        word_cnt_q <= '0;
      end else begin
        if (err_evt && err_cnt_q != CNT_MAX)   err_cnt_q  <= err_cnt_q + 1'b1;
        if (word_evt && word_cnt_q != CNT_MAX) word_cnt_q <= word_cnt_q + 1'b1;
      end

      // A lock loss beats a same-cycle clear of the sticky flag.
      if (loss_evt)         lock_lost_q <= 1'b1;
      else if (bus.i_clear) lock_lost_q <= 1'b0;
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_locked     = (state_q == ST_LOCKED);
  assign bus.o_err_pulse  = err_pulse_q;
  assign bus.o_err_count  = err_cnt_q;
  assign bus.o_word_count = word_cnt_q;
  assign bus.o_lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model pushes expected outputs per
// driven cycle, each scenario task pops and compares them after the clock edge.
module tb_prbs_checker;

  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;

  typedef struct packed {
    logic [1:0]  state;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic        lock_lost;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  prbs_checker_if #(.NUM_BITS(9), .CNT_W(16)) bus ();

  prbs_checker #(
    .NUM_BITS   (9),
    .TAP_A      (9),
    .TAP_B      (5),
    .LOCK_COUNT (LOCK_N),
    .LOSS_COUNT (LOSS_N),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_run  = 0;
  int   n_fail = 0;
  obs_t sb_q[$];

  // Reference model state.
  logic [1:0] m_state = 2'd0;
  logic [8:0] m_ref   = '0;
  int         m_match = 0;
  int         m_miss  = 0;
  obs_t       m_out   = '0;

  // Generator-side position in the sequence.
  logic [8:0] g = '0;

  logic [8:0] lock_seq [9] = '{9'h000, 9'h001, 9'h003, 9'h007, 9'h00F,
                               9'h01F, 9'h03E, 9'h07C, 9'h0F8};

  function automatic logic [8:0] gen_next(logic [8:0] s);
    return {s[7:0], ~(s[8] ^ s[4])};
  endfunction

  function automatic obs_t sample();
    return {bus.o_state, bus.o_locked, bus.o_err_pulse,
            bus.o_err_count, bus.o_word_count, bus.o_lock_lost};
  endfunction

  task automatic model_step(input bit rst, input bit clr, input bit v, input logic [8:0] d);
    obs_t o;
    bit   loss;
    o = m_out;
    o.err_pulse = 1'b0;
    loss = 1'b0;
    if (rst) begin
      m_state = 2'd0; m_ref = '0; m_match = 0; m_miss = 0;
      o = '0;
    end else begin
      if (v) begin
        case (m_state)
          2'd0: if (d != 9'h1FF) begin
            m_ref = d; m_match = 0; m_state = 2'd1;
          end
          2'd1: begin
            if (d == gen_next(m_ref)) begin
              m_match++;
              if (m_match == LOCK_N) begin m_state = 2'd2; m_miss = 0; end
            end else begin
              m_match = 0;
            end
            m_ref = d;
          end
          default: begin
            if (o.word_count != 16'hFFFF) o.word_count++;
            if (d == gen_next(m_ref)) begin
              m_miss = 0;
            end else begin
              o.err_pulse = 1'b1;
              if (o.err_count != 16'hFFFF) o.err_count++;
              m_miss++;
              if (m_miss == LOSS_N) begin m_state = 2'd0; loss = 1'b1; m_match = 0; end
            end
            m_ref = gen_next(m_ref);
          end
        endcase
      end
      if (clr) begin o.err_count = '0; o.word_count = '0; o.lock_lost = 1'b0; end
      if (loss) o.lock_lost = 1'b1;
    end
    o.state  = m_state;
    o.locked = (m_state == 2'd2);
    m_out = o;
    sb_q.push_back(o);
  endtask

  task automatic drive(input bit rst, input bit clr, input bit v, input logic [8:0] d);
    reset       = rst;
    bus.i_clear = clr;
    bus.i_valid = v;
    bus.i_data  = d;
    model_step(rst, clr, v, d);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  // Drives the lock sequence (optionally with idle gaps), checking every cycle.
  task automatic feed_lock(input string name, input bit gaps);
    obs_t exp, act;
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        int n_gap = $urandom_range(7, 0);
        for (int k = 0; k < n_gap; k++) begin
          drive(1'b0, 1'b0, 1'b0, 9'h1FF);
          exp = sb_q.pop_front(); act = sample(); n_run++;
          if (act !== exp) begin
            n_fail++;
            $display("FAIL %s gap w%0d: got %h expected %h", name, i, act, exp);
          end
        end
      end
      drive(1'b0, 1'b0, 1'b1, lock_seq[i]);
      exp = sb_q.pop_front(); act = sample(); n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h expected %h", name, i, act, exp);
      end
    end
    g = 9'h0F8;
  endtask

  task automatic test_reset();
    obs_t exp, act;
    drive(1'b1, 1'b0, 1'b0, '0);
    exp = sb_q.pop_front(); act = sample(); n_run++;
    if (act !== exp || act !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act, exp);
    end
  endtask

  task automatic test_lock();
    obs_t act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    feed_lock("t1_lock", 1'b0);
    act = sample(); n_run++;
    if (act.state !== 2'd2 || act.locked !== 1'b1 || act.err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL t1_final: got state %0d locked %0d err %0d expected 2 1 0",
               act.state, act.locked, act.err_count);
    end
  endtask

  task automatic test_single_error();
    obs_t exp, act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    feed_lock("t2_prelock", 1'b0);
    for (int i = 0; i < 7; i++) begin
      g = gen_next(g);
      drive(1'b0, 1'b0, 1'b1, (i == 3) ? (g ^ 9'h001) : g);
      exp = sb_q.pop_front(); act = sample(); n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL t2_single_err word %0d: got %h expected %h", i, act, exp);
      end
    end
    act = sample(); n_run++;
    if (act.err_count !== 16'd1 || act.word_count !== 16'd7 || act.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_final: got err %0d words %0d locked %0d expected 1 7 1",
               act.err_count, act.word_count, act.locked);
    end
  endtask

  task automatic test_loss();
    obs_t exp, act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    feed_lock("t3_prelock", 1'b0);
    for (int i = 0; i < LOSS_N; i++) begin
      g = gen_next(g);
      drive(1'b0, 1'b0, 1'b1, g ^ 9'h010);
      exp = sb_q.pop_front(); act = sample(); n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL t3_loss word %0d: got %h expected %h", i, act, exp);
      end
    end
    act = sample(); n_run++;
    if (act.state !== 2'd0 || act.lock_lost !== 1'b1 || act.err_count !== 16'd4) begin
      n_fail++;
      $display("FAIL t3_final: got state %0d lost %0d err %0d expected 0 1 4",
               act.state, act.lock_lost, act.err_count);
    end
  endtask

  task automatic test_lockup();
    obs_t exp, act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 9'h1FF);
      exp = sb_q.pop_front(); act = sample(); n_run++;
      if (act !== exp || act !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL t4_lockup cycle %0d: got %h expected %h", i, act, exp);
      end
    end
  endtask

  task automatic test_valid_gaps();
    obs_t act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    feed_lock("t5_gaps", 1'b1);
    act = sample(); n_run++;
    if (act.state !== 2'd2 || act.err_count !== 16'd0 || act.word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL t5_final: got state %0d err %0d words %0d expected 2 0 0",
               act.state, act.err_count, act.word_count);
    end
  endtask

  task automatic test_clear_reset();
    obs_t exp, act;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb_q.pop_front());
    feed_lock("t6_prelock", 1'b0);
    // Mismatches; clear lands on the first one and on the lock-dropping fourth one.
    for (int i = 0; i < LOSS_N; i++) begin
      g = gen_next(g);
      drive(1'b0, (i == 0 || i == LOSS_N - 1), 1'b1, g ^ 9'h100);
      exp = sb_q.pop_front(); act = sample(); n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL t6_clear word %0d: got %h expected %h", i, act, exp);
      end
      if (i == 0) begin
        n_run++;
        if (act.err_count !== 16'd0 || act.err_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL t6_clear_wins: got err %0d pulse %0d expected 0 1",
                   act.err_count, act.err_pulse);
        end
      end
    end
    act = sample(); n_run++;
    if (act.lock_lost !== 1'b1 || act.err_count !== 16'd0 || act.state !== 2'd0) begin
      n_fail++;
      $display("FAIL t6_set_wins: got lost %0d err %0d state %0d expected 1 0 0",
               act.lock_lost, act.err_count, act.state);
    end
    // Enter VERIFY, then reset mid-run.
    drive(1'b0, 1'b0, 1'b1, 9'h003);
    drive(1'b0, 1'b0, 1'b1, 9'h007);
    for (int i = 0; i < 2; i++) begin
      exp = sb_q.pop_front(); act = sample();
    end
    n_run++;
    if (act.state !== 2'd1 || act !== exp) begin
      n_fail++;
      $display("FAIL t6_verify: got %h expected %h", act, exp);
    end
    drive(1'b1, 1'b0, 1'b1, 9'h00F);
    exp = sb_q.pop_front(); act = sample(); n_run++;
    if (act !== exp || act !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL t6_reset_mid_verify: got %h expected %h", act, exp);
    end
  endtask

  initial begin
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_lockup();
    test_valid_gaps();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
